// File: rtl/bp_fe_bp_update_ctrl.sv
// Branch-predictor table-port controller: post-reset/flush clear sweep, update FIFO, fetch/write arbitration.
// Optional same-cycle update bypass when BP_FE_BP_UPDATE_BYPASS_EN is defined.
module bp_fe_bp_update_ctrl #(
    parameter int eaddr_width_p    = 16,
    parameter int btb_indx_width_p = 4,
    parameter int bht_indx_width_p = 3,
    parameter int fifo_els_p       = 2,
    parameter int starve_limit_p   = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        flush_i,
    // Update handshake: a transfer happens in exactly the cycles where upd_v_i and upd_ready_o are both 1.
    input  logic                        upd_v_i,
    output logic                        upd_ready_o,
    input  logic                        upd_correct_i,
    input  logic [btb_indx_width_p-1:0] upd_btb_indx_i,
    input  logic [bht_indx_width_p-1:0] upd_bht_indx_i,
    input  logic [eaddr_width_p-1:0]    upd_tgt_i,
    input  logic                        fetch_r_v_i,
    output logic                        fetch_stall_o,
    output logic                        tbl_r_v_o,
    output logic                        tbl_w_v_o,
    output logic                        tbl_w_clear_o,
    output logic                        tbl_w_correct_o,
    output logic [btb_indx_width_p-1:0] tbl_w_btb_indx_o,
    output logic [bht_indx_width_p-1:0] tbl_w_bht_indx_o,
    output logic [eaddr_width_p-1:0]    tbl_w_tgt_o,
    output logic                        busy_o,
    output logic                        dbg_state_o
);

    localparam int sweep_w_lp  = (btb_indx_width_p > bht_indx_width_p) ? btb_indx_width_p : bht_indx_width_p;
    localparam int ptr_w_lp    = $clog2(fifo_els_p);
    localparam int cnt_w_lp    = ptr_w_lp + 1;
    localparam int starve_w_lp = $clog2(starve_limit_p + 1);
    localparam int entry_w_lp  = 1 + btb_indx_width_p + bht_indx_width_p + eaddr_width_p;

    localparam logic [0:0] state_clear = 1'b0;
    localparam logic [0:0] state_run   = 1'b1;

    localparam logic [cnt_w_lp-1:0]    fifo_full_lp  = cnt_w_lp'(fifo_els_p);
    localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

    logic [0:0]             state_r;
    logic [sweep_w_lp-1:0]  sweep_r;
    logic [ptr_w_lp-1:0]    wr_ptr_r;
    logic [ptr_w_lp-1:0]    rd_ptr_r;
    logic [cnt_w_lp-1:0]    count_r;
    logic [starve_w_lp-1:0] starve_r;
    logic [entry_w_lp-1:0]  mem_r [fifo_els_p];

    logic                        in_run;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic                        starve_hit;
    logic                        write_win;
    logic                        bypass_w;
    logic                        upd_fire;
    logic [entry_w_lp-1:0]       upd_entry;
    logic [entry_w_lp-1:0]       head_entry;
    logic                        head_correct;
    logic [btb_indx_width_p-1:0] head_btb;
    logic [bht_indx_width_p-1:0] head_bht;
    logic [eaddr_width_p-1:0]    head_tgt;

    assign in_run     = (state_r == state_run) && !reset_i;
    assign fifo_empty = (count_r == '0);
    assign fifo_full  = (count_r == fifo_full_lp);
    assign starve_hit = (starve_r == starve_max_lp);

    assign upd_entry  = {upd_correct_i, upd_btb_indx_i, upd_bht_indx_i, upd_tgt_i};
    assign head_entry = mem_r[rd_ptr_r];
    assign {head_correct, head_btb, head_bht, head_tgt} = head_entry;

    // A flushing cycle neither accepts nor drains updates: everything queued is about to be discarded.
    assign upd_ready_o = in_run && !flush_i && !fifo_full;
    assign write_win   = in_run && !flush_i && !fifo_empty
                         && (!fetch_r_v_i || fifo_full || starve_hit);

`ifdef BP_FE_BP_UPDATE_BYPASS_EN
    assign bypass_w = upd_ready_o && fifo_empty && !fetch_r_v_i && upd_v_i;
`else
    assign bypass_w = 1'b0;
`endif

    assign upd_fire = upd_v_i && upd_ready_o && !bypass_w;

    assign busy_o        = reset_i || (state_r == state_clear);
    assign tbl_r_v_o     = in_run && fetch_r_v_i && !write_win;
    assign fetch_stall_o = fetch_r_v_i && !tbl_r_v_o;
    assign dbg_state_o   = state_r;

    always_comb begin
        tbl_w_v_o        = 1'b0;
        tbl_w_clear_o    = 1'b0;
        tbl_w_correct_o  = 1'b0;
        tbl_w_btb_indx_o = '0;
        tbl_w_bht_indx_o = '0;
        tbl_w_tgt_o      = '0;
        if (!reset_i) begin
            if (state_r == state_clear) begin
                tbl_w_v_o        = 1'b1;
                tbl_w_clear_o    = 1'b1;
                tbl_w_btb_indx_o = sweep_r[btb_indx_width_p-1:0];
                tbl_w_bht_indx_o = sweep_r[bht_indx_width_p-1:0];
            end else if (write_win) begin
                tbl_w_v_o        = 1'b1;
                tbl_w_correct_o  = head_correct;
                tbl_w_btb_indx_o = head_btb;
                tbl_w_bht_indx_o = head_bht;
                tbl_w_tgt_o      = head_tgt;
            end else if (bypass_w) begin
                tbl_w_v_o        = 1'b1;
                tbl_w_correct_o  = upd_correct_i;
                tbl_w_btb_indx_o = upd_btb_indx_i;
                tbl_w_bht_indx_o = upd_bht_indx_i;
                tbl_w_tgt_o      = upd_tgt_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= state_clear;
            sweep_r <= '0;
        end else if (flush_i) begin
            state_r <= state_clear;
            sweep_r <= '0;
        end else if (state_r == state_clear) begin
            sweep_r <= sweep_r + sweep_w_lp'(1);
            if (sweep_r == '1) begin
                state_r <= state_run;
            end
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (upd_fire) begin
                wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
            end
            if (write_win) begin
                rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
            end
            case ({upd_fire, write_win})
                2'b10:   count_r <= count_r + cnt_w_lp'(1);
                2'b01:   count_r <= count_r - cnt_w_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (upd_fire) begin
            mem_r[wr_ptr_r] <= upd_entry;
        end
    end

    // Counts cycles a queued update has lost to fetch; reaching the limit forces the next write.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            starve_r <= '0;
        end else if (flush_i || !in_run || write_win || fifo_empty) begin
            starve_r <= '0;
        end else if (!starve_hit) begin
            starve_r <= starve_r + starve_w_lp'(1);
        end
    end

endmodule

// File: tb/tb_bp_fe_bp_update_ctrl.sv
// Directed bench for bp_fe_bp_update_ctrl: sweep, update latency, starvation, full FIFO, flush, mid-sweep reset.
module tb_bp_fe_bp_update_ctrl;

    localparam int EW  = 16;
    localparam int BTW = 4;
    localparam int BHW = 3;

    logic           clk;
    logic           reset_i;
    logic           flush_i;
    logic           upd_v_i;
    logic           upd_ready_o;
    logic           upd_correct_i;
    logic [BTW-1:0] upd_btb_indx_i;
    logic [BHW-1:0] upd_bht_indx_i;
    logic [EW-1:0]  upd_tgt_i;
    logic           fetch_r_v_i;
    logic           fetch_stall_o;
    logic           tbl_r_v_o;
    logic           tbl_w_v_o;
    logic           tbl_w_clear_o;
    logic           tbl_w_correct_o;
    logic [BTW-1:0] tbl_w_btb_indx_o;
    logic [BHW-1:0] tbl_w_bht_indx_o;
    logic [EW-1:0]  tbl_w_tgt_o;
    logic           busy_o;
    logic           dbg_state_o;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    bp_fe_bp_update_ctrl #(
        .eaddr_width_p   (EW),
        .btb_indx_width_p(BTW),
        .bht_indx_width_p(BHW),
        .fifo_els_p      (2),
        .starve_limit_p  (4)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .flush_i         (flush_i),
        .upd_v_i         (upd_v_i),
        .upd_ready_o     (upd_ready_o),
        .upd_correct_i   (upd_correct_i),
        .upd_btb_indx_i  (upd_btb_indx_i),
        .upd_bht_indx_i  (upd_bht_indx_i),
        .upd_tgt_i       (upd_tgt_i),
        .fetch_r_v_i     (fetch_r_v_i),
        .fetch_stall_o   (fetch_stall_o),
        .tbl_r_v_o       (tbl_r_v_o),
        .tbl_w_v_o       (tbl_w_v_o),
        .tbl_w_clear_o   (tbl_w_clear_o),
        .tbl_w_correct_o (tbl_w_correct_o),
        .tbl_w_btb_indx_o(tbl_w_btb_indx_o),
        .tbl_w_bht_indx_o(tbl_w_bht_indx_o),
        .tbl_w_tgt_o     (tbl_w_tgt_o),
        .busy_o          (busy_o),
        .dbg_state_o     (dbg_state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic v, input logic clr, input logic corr,
                         input logic [BTW-1:0] btb, input logic [BHW-1:0] bht, input logic [EW-1:0] tgt);
        chk({tag, ".w_v"},     64'(tbl_w_v_o),        64'(v));
        chk({tag, ".w_clear"}, 64'(tbl_w_clear_o),    64'(clr));
        chk({tag, ".w_corr"},  64'(tbl_w_correct_o),  64'(corr));
        chk({tag, ".w_btb"},   64'(tbl_w_btb_indx_o), 64'(btb));
        chk({tag, ".w_bht"},   64'(tbl_w_bht_indx_o), 64'(bht));
        chk({tag, ".w_tgt"},   64'(tbl_w_tgt_o),      64'(tgt));
    endtask

    task automatic chk_ctl(input string tag, input logic r_v, input logic stall,
                           input logic ready, input logic busy);
        chk({tag, ".r_v"},   64'(tbl_r_v_o),     64'(r_v));
        chk({tag, ".stall"}, 64'(fetch_stall_o), 64'(stall));
        chk({tag, ".ready"}, 64'(upd_ready_o),   64'(ready));
        chk({tag, ".busy"},  64'(busy_o),        64'(busy));
    endtask

    task automatic chk_idle_w(input string tag);
        chk_w(tag, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic chk_sweep(input int i);
        chk_w("sweep", 1'b1, 1'b1, 1'b0, BTW'(i), BHW'(i), '0);
        chk("sweep.busy", 64'(busy_o), 64'd1);
        chk("sweep.ready", 64'(upd_ready_o), 64'd0);
        chk("sweep.stall", 64'(fetch_stall_o), 64'(fetch_r_v_i));
    endtask

    task automatic drive_upd(input logic v, input logic corr, input logic [BTW-1:0] btb,
                             input logic [BHW-1:0] bht, input logic [EW-1:0] tgt);
        upd_v_i        = v;
        upd_correct_i  = corr;
        upd_btb_indx_i = btb;
        upd_bht_indx_i = bht;
        upd_tgt_i      = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_i     = 1'b1;
        flush_i     = 1'b0;
        fetch_r_v_i = 1'b1;
        drive_upd(1'b0, 1'b0, '0, '0, '0);
        #3;
        chk_ctl("reset", 1'b0, 1'b1, 1'b0, 1'b1);
        chk_idle_w("reset");
        step();
        step();

        // Full sweep after reset release: 16 clear writes at indices 0..15.
        reset_i = 1'b0;
        settle();
        for (int i = 0; i < 16; i++) begin
            chk_sweep(i);
            step();
            settle();
        end
        chk_ctl("run_entry", 1'b1, 1'b0, 1'b1, 1'b0);
        chk_idle_w("run_entry");

        // Idle fetch: single update written one cycle after acceptance.
        fetch_r_v_i = 1'b0;
        drive_upd(1'b1, 1'b0, 4'd3, 3'd5, 16'h0080);
        settle();
        chk("upd.ready", 64'(upd_ready_o), 64'd1);
`ifdef BP_FE_BP_UPDATE_BYPASS_EN
        chk_w("upd_n", 1'b1, 1'b0, 1'b0, 4'd3, 3'd5, 16'h0080);
        step();
        drive_upd(1'b0, 1'b0, '0, '0, '0);
        settle();
        chk_idle_w("upd_n1");
`else
        chk_idle_w("upd_n");
        step();
        drive_upd(1'b0, 1'b0, '0, '0, '0);
        settle();
        chk_w("upd_n1", 1'b1, 1'b0, 1'b0, 4'd3, 3'd5, 16'h0080);
        chk_ctl("upd_n1", 1'b0, 1'b0, 1'b1, 1'b0);
`endif
        step();
        settle();
        chk_idle_w("upd_done");

        // Fetch held: a pending update loses four times, then wins once.
        fetch_r_v_i = 1'b1;
        drive_upd(1'b1, 1'b1, 4'd7, 3'd2, 16'h1234);
        settle();
        chk_ctl("starve_enq", 1'b1, 1'b0, 1'b1, 1'b0);
        chk_idle_w("starve_enq");
        step();
        drive_upd(1'b0, 1'b0, '0, '0, '0);
        settle();
        for (int k = 0; k < 4; k++) begin
            chk_ctl("starve_rd", 1'b1, 1'b0, 1'b1, 1'b0);
            chk_idle_w("starve_rd");
            step();
            settle();
        end
        chk_w("starve_w", 1'b1, 1'b0, 1'b1, 4'd7, 3'd2, 16'h1234);
        chk_ctl("starve_w", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        settle();
        chk_ctl("starve_after", 1'b1, 1'b0, 1'b1, 1'b0);
        chk_idle_w("starve_after");

        // Two updates fill the FIFO; the full FIFO forces a write, a third offer is refused.
        drive_upd(1'b1, 1'b1, 4'd1, 3'd1, 16'h0011);
        settle();
        chk("fullA.ready", 64'(upd_ready_o), 64'd1);
        step();
        drive_upd(1'b1, 1'b0, 4'd2, 3'd6, 16'h0022);
        settle();
        chk_ctl("fullB", 1'b1, 1'b0, 1'b1, 1'b0);
        chk_idle_w("fullB");
        step();
        drive_upd(1'b1, 1'b1, 4'd9, 3'd4, 16'h0099);
        settle();
        chk_ctl("full", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_w("full_wA", 1'b1, 1'b0, 1'b1, 4'd1, 3'd1, 16'h0011);
        step();
        drive_upd(1'b0, 1'b0, '0, '0, '0);
        settle();
        for (int k = 0; k < 4; k++) begin
            chk_ctl("drain_rd", 1'b1, 1'b0, 1'b1, 1'b0);
            chk_idle_w("drain_rd");
            step();
            settle();
        end
        chk_w("drain_wB", 1'b1, 1'b0, 1'b0, 4'd2, 3'd6, 16'h0022);
        chk_ctl("drain_wB", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        settle();
        chk_idle_w("drain_empty");
        chk_ctl("drain_empty", 1'b1, 1'b0, 1'b1, 1'b0);

        // Flush with two pending updates: nothing written, sweep restarts at 0.
        drive_upd(1'b1, 1'b1, 4'd5, 3'd3, 16'h0055);
        step();
        drive_upd(1'b1, 1'b0, 4'd6, 3'd4, 16'h0066);
        step();
        drive_upd(1'b1, 1'b1, 4'd7, 3'd7, 16'h0077);
        flush_i = 1'b1;
        settle();
        chk("flush.ready", 64'(upd_ready_o), 64'd0);
        chk("flush.busy", 64'(busy_o), 64'd0);
        chk_idle_w("flush_cyc");
        step();
        flush_i = 1'b0;
        drive_upd(1'b0, 1'b0, '0, '0, '0);
        settle();
        for (int i = 0; i < 16; i++) begin
            chk_sweep(i);
            step();
            settle();
        end
        fetch_r_v_i = 1'b0;
        settle();
        chk_ctl("post_flush", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_idle_w("post_flush");
        step();
        settle();
        chk_idle_w("post_flush2");

        // Flush during the sweep restarts it; reset at index 9 restarts it again.
        fetch_r_v_i = 1'b1;
        flush_i = 1'b1;
        settle();
        step();
        flush_i = 1'b0;
        settle();
        for (int i = 0; i < 5; i++) begin
            chk_sweep(i);
            step();
            settle();
        end
        chk_sweep(5);
        flush_i = 1'b1;
        settle();
        step();
        flush_i = 1'b0;
        settle();
        for (int i = 0; i < 9; i++) begin
            chk_sweep(i);
            step();
            settle();
        end
        chk_sweep(9);
        reset_i = 1'b1;
        settle();
        chk_ctl("mid_reset", 1'b0, 1'b1, 1'b0, 1'b1);
        chk_idle_w("mid_reset");
        step();
        reset_i = 1'b0;
        settle();
        for (int i = 0; i < 16; i++) begin
            chk_sweep(i);
            step();
            settle();
        end
        chk_ctl("final_run", 1'b1, 1'b0, 1'b1, 1'b0);
        chk_idle_w("final_run");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bp_fe_bp_update_ctrl.md
# bp_fe_bp_update_ctrl

Controller that owns the branch predictor's shared table-access port in the front end. It clears BHT/BTB tables by index sweep after reset or flush. It buffers backend training updates (attaboy/mispredict) in a small FIFO. It arbitrates each cycle between fetch lookups and buffered writes, with a bounded-starvation rule. It sits between the FE command path, pc-gen fetch logic and the BHT/BTB pair.

## Interface
- eaddr_width_p, "inv", effective-address / branch-target width
- btb_indx_width_p, "inv", BTB index width
- bht_indx_width_p, "inv", BHT index width
- fifo_els_p, 2, update FIFO depth (power of two, ≥2)
- starve_limit_p, 4, max consecutive cycles a pending update may lose to fetch
- clk_i  in  1  clock; all state on rising edge
- reset_i  in  1  asynchronous, active-high reset
- flush_i  in  1  drop pending updates, restart table clear sweep
- upd_v_i  in  1  backend update valid
- upd_ready_o  out  1  controller accepts update this cycle
- upd_correct_i  in  1  1 = attaboy (prediction correct), 0 = mispredict
- upd_btb_indx_i  in  btb_indx_width_p  BTB write index
- upd_bht_indx_i  in  bht_indx_width_p  BHT write index
- upd_tgt_i  in  eaddr_width_p  resolved branch target
- fetch_r_v_i  in  1  fetch requests a table lookup
- fetch_stall_o  out  1  lookup denied this cycle; fetch must retry
- tbl_r_v_o  out  1  lookup issued to tables
- tbl_w_v_o  out  1  write issued to tables
- tbl_w_clear_o  out  1  write is a clear (entry invalid, counter weakly-not-taken)
- tbl_w_correct_o  out  1  training outcome for BHT
- tbl_w_btb_indx_o  out  btb_indx_width_p  write index
- tbl_w_bht_indx_o  out  bht_indx_width_p  write index
- tbl_w_tgt_o  out  eaddr_width_p  write target (0 on clear)
- busy_o  out  1  clear sweep in progress

## Operation
- States: CLEAR, RUN. Reset enters CLEAR with sweep counter 0.
- CLEAR: W = max(btb_indx_width_p, bht_indx_width_p). Each cycle: tbl_w_v_o=1, tbl_w_clear_o=1, indices = counter truncated to each width. Counter increments. After writing index 2^W−1, the next state is RUN.
- CLEAR: tbl_r_v_o=0, fetch_stall_o=fetch_r_v_i, upd_ready_o=0, busy_o=1.
- RUN: upd_ready_o = FIFO not full. Enqueue on upd_v_i & upd_ready_o.
- RUN arbitration, write wins when FIFO non-empty and any of the following holds:
  - fetch_r_v_i=0
  - FIFO full
  - starve count = starve_limit_p
- Write wins: dequeue head, drive tbl_w_* from it, tbl_r_v_o=0, fetch_stall_o=fetch_r_v_i.
- Otherwise: tbl_r_v_o=fetch_r_v_i, fetch_stall_o=0.
- Starve counter: increments on each cycle where the FIFO is non-empty and a read wins. It clears on any write or when the FIFO is empty. It saturates at starve_limit_p.
- Full FIFO: upd_ready_o=0. No enqueue-while-dequeue-when-full.
- flush_i (any state) takes effect next cycle:
  - FIFO emptied, starve counter 0
  - state CLEAR, sweep counter 0
  - flush_i during CLEAR restarts the sweep
  - an update offered in the flush cycle is not accepted (upd_ready_o=0 that cycle)
- FIFO pointers wrap modulo fifo_els_p. An occupancy counter of width log2(fifo_els_p)+1 distinguishes full from empty.

## Timing
- While reset_i=1: busy_o=1; upd_ready_o=0, tbl_r_v_o=0, tbl_w_v_o=0, tbl_w_clear_o=0, fetch_stall_o=fetch_r_v_i; data outputs 0. The sweep starts the first edge after deassert.
- Sweep length: exactly 2^W cycles. busy_o falls the cycle after the last clear write.
- Update latency: accepted at cycle N, written no earlier than N+1. Fetch pressure can delay the write at most starve_limit_p cycles once the update is at the FIFO head.
- All tbl_w_* outputs come from registered FIFO head / counter. tbl_r_v_o and fetch_stall_o are combinational from registered state and fetch_r_v_i.

## Configuration
- BP_FE_BP_UPDATE_BYPASS_EN defined: in RUN with FIFO empty, fetch_r_v_i=0 and upd_v_i=1, the update is written the same cycle (tbl_w_* = upd_* inputs) and not enqueued. Latency is 0.
- Undefined: every update passes through the FIFO. Minimum latency is 1 cycle.

## Test plan
- Reset, W=4 → busy_o high 16 cycles; clear writes at indices 0..15, one per cycle; busy_o falls in cycle 17; upd_ready_o rises.
- Idle fetch, update (btb=3, bht=5, tgt=0x80, correct=0) at cycle N → tbl_w_v_o at N+1 with those values. With BYPASS_EN the write occurs at N.
- fetch_r_v_i held 1, one pending update, starve_limit_p=4 → 4 reads issued, then 1 write with fetch_stall_o=1, then reads resume.
- fifo_els_p=2, fetch held 1, 2 updates enqueued → upd_ready_o=0; writes win while full; FIFO drains in FIFO order.
- flush_i with 2 pending updates mid-RUN → no tbl_w_v_o for those updates; CLEAR sweep restarts at index 0; busy_o=1 next cycle.
- reset_i asserted mid-sweep at index 9 → outputs take reset values immediately; after deassert the sweep restarts from 0.
